sub_mul_acc: RTL and testbench

// - Downstream consumer of the sub_mul DSP pipeline: accumulates its signed (d-a)*b product stream into frame sums.
// - Frame ends after FRAME_LEN samples or on in_last; each sum is queued in a small output FIFO and drained via valid/ready.
// - sub_mul cannot stall, so there is no input backpressure. A frame result that finds the FIFO full is dropped and flagged.

---
 rtl/sub_mul_acc.sv | 180 ++++++++++++++++++
 tb/tb_sub_mul_acc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_mul_acc.sv
// sub_mul_acc: accumulates the signed sub_mul product stream into frame sums queued in a small output FIFO.
// Define SUB_MUL_ACC_SAT_EN for saturating accumulation with a per-frame saturation flag (default: wraparound).
module sub_mul_acc #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_data,
  output logic [$clog2(FRAME_LEN+1)-1:0]   out_count,
  output logic                             out_sat,
  output logic                             busy,
  output logic                             overflow,
  input  logic                             clr_overflow
);

  localparam int CNT_W = $clog2(FRAME_LEN+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN-1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fsat_q, fsat_d;
  logic               overflow_q, overflow_d;

  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   sum;
  logic               clamp;
  logic [CNT_W-1:0]   cnt_inc;
  logic               closing;
  logic               push_req;

  logic [ACC_W-1:0]   mem_data_q [DEPTH];
  logic [CNT_W-1:0]   mem_cnt_q  [DEPTH];
  logic               mem_sat_q  [DEPTH];
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
  logic               full, empty, pop, push, drop;

  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;

  assign in_ext  = ACC_W'($signed(in_data));
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign closing = in_valid && (in_last || (cnt_q == LAST_CNT));

`ifdef SUB_MUL_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {in_ext[ACC_W-1], in_ext};
  assign clamp    = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);

  // An out-of-range sum clamps toward the side its true sign points to.
  always_comb begin
    sum = sum_wide[ACC_W-1:0];
    if (clamp) begin
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum   = acc_q + in_ext;
  assign clamp = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fsat_d   = fsat_q;
    push_req = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (in_valid) begin
          if (closing) begin
            push_req = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            fsat_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            acc_d    = sum;
            cnt_d    = cnt_inc;
            fsat_d   = fsat_q | clamp;
            state_d  = ACCUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      fsat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fsat_q  <= fsat_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  assign rd_ptr_n   = rd_ptr_q + (PTR_W+1)'(pop);
  assign wr_ptr_n   = wr_ptr_q + (PTR_W+1)'(push);
  assign overflow_d = drop | (overflow_q & ~clr_overflow);

  // The head register follows the FIFO head but holds its last value when the FIFO runs empty.
  // If the new head is the entry being written this cycle, it is taken straight from the push data.
  always_comb begin
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (rd_ptr_n != wr_ptr_n) begin
      if (rd_ptr_n == wr_ptr_q) begin
        out_data_d  = sum;
        out_count_d = cnt_inc;
        out_sat_d   = fsat_q | clamp;
      end else begin
        out_data_d  = mem_data_q[rd_ptr_n[PTR_W-1:0]];
        out_count_d = mem_cnt_q[rd_ptr_n[PTR_W-1:0]];
        out_sat_d   = mem_sat_q[rd_ptr_n[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_cnt_q[i]  <= '0;
        mem_sat_q[i]  <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q[PTR_W-1:0]] <= sum;
        mem_cnt_q[wr_ptr_q[PTR_W-1:0]]  <= cnt_inc;
        mem_sat_q[wr_ptr_q[PTR_W-1:0]]  <= fsat_q | clamp;
      end
      wr_ptr_q    <= wr_ptr_n;
      rd_ptr_q    <= rd_ptr_n;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q == ACCUM);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sub_mul_acc.sv
// Self-checking bench for sub_mul_acc: directed vector table, hand-written corner sequences and
// randomized traffic compared against a queue-based frame model.
module tb_sub_mul_acc;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 24;
  localparam int FRAME_LEN = 8;
  localparam int DEPTH     = 2;
  localparam int CNT_W     = $clog2(FRAME_LEN+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inValid = 1'b0;
  logic [DATA_W-1:0] inData = '0;
  logic              inLast = 1'b0;
  logic              outReady = 1'b0;
  logic              clrOverflow = 1'b0;
  logic              outValid;
  logic [ACC_W-1:0]  outData;
  logic [CNT_W-1:0]  outCount;
  logic              outSat;
  logic              busy;
  logic              overflow;

  logic              s16Valid = 1'b0;
  logic [15:0]       s16Data = '0;
  logic              s16Last = 1'b0;
  logic              s16Ready = 1'b1;
  logic              s16OutValid;
  logic [15:0]       s16OutData;
  logic [CNT_W-1:0]  s16OutCount;
  logic              s16OutSat;
  logic              s16Busy;
  logic              s16Overflow;

  int errors = 0;
  int checks = 0;

  sub_mul_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_data(inData), .in_last(inLast),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_count(outCount),
    .out_sat(outSat), .busy(busy), .overflow(overflow), .clr_overflow(clrOverflow)
  );

  sub_mul_acc #(.DATA_W(16), .ACC_W(16), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s16Valid), .in_data(s16Data), .in_last(s16Last),
    .out_valid(s16OutValid), .out_ready(s16Ready), .out_data(s16OutData), .out_count(s16OutCount),
    .out_sat(s16OutSat), .busy(s16Busy), .overflow(s16Overflow), .clr_overflow(1'b0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: frame results as a bounded queue, accumulator as a plain integer.
  typedef struct {
    longint data;
    int     cnt;
    bit     sat;
  } res_t;

  res_t   mq[$];
  res_t   mHead;
  longint mAcc;
  int     mCnt;
  bit     mSat;
  bit     mOvf;

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

  function automatic bit clampHit(input longint x);
`ifdef SUB_MUL_ACC_SAT_EN
    return (x > ACC_MAX) || (x < ACC_MIN);
`else
    return (x > ACC_MAX) && (x < ACC_MIN);
`endif
  endfunction

  function automatic longint fitAcc(input longint x);
    longint m;
    longint r;
`ifdef SUB_MUL_ACC_SAT_EN
    if (x > ACC_MAX) return ACC_MAX;
    if (x < ACC_MIN) return ACC_MIN;
    return x;
`else
    m = longint'(1) <<< ACC_W;
    r = x % m;
    if (r < 0) r = r + m;
    if (r > ACC_MAX) r = r - m;
    return r;
`endif
  endfunction

  task automatic modelReset();
    mq.delete();
    mHead = '{0, 0, 1'b0};
    mAcc  = 0;
    mCnt  = 0;
    mSat  = 1'b0;
    mOvf  = 1'b0;
  endtask

  task automatic modelStep(input logic v, input logic [DATA_W-1:0] d, input logic last,
                           input logic ready, input logic clr);
    bit     pop;
    bit     push;
    bit     drop;
    bit     cl;
    longint raw;
    longint s;
    res_t   r;
    pop  = (mq.size() != 0) && ready;
    push = 1'b0;
    drop = 1'b0;
    r    = '{0, 0, 1'b0};
    if (v) begin
      raw = mAcc + longint'($signed(d));
      cl  = clampHit(raw);
      s   = fitAcc(raw);
      if (last || mCnt == FRAME_LEN-1) begin
        r    = '{s, mCnt + 1, mSat | cl};
        push = 1'b1;
        mAcc = 0;
        mCnt = 0;
        mSat = 1'b0;
      end else begin
        mAcc = s;
        mCnt = mCnt + 1;
        mSat = mSat | cl;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else drop = 1'b1;
    end
    if (drop) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
    if (mq.size() != 0) mHead = mq[0];
  endtask

  task automatic checkEq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [ACC_W-1:0] expData,
                             input int expCount, input logic expSat, input logic expBusy,
                             input logic expOvf);
    checkEq({name, ".out_valid"}, longint'(outValid), longint'(expValid));
    checkEq({name, ".out_data"},  longint'(outData),  longint'(expData));
    checkEq({name, ".out_count"}, longint'(outCount), longint'(expCount));
    checkEq({name, ".out_sat"},   longint'(outSat),   longint'(expSat));
    checkEq({name, ".busy"},      longint'(busy),     longint'(expBusy));
    checkEq({name, ".overflow"},  longint'(overflow), longint'(expOvf));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mq.size() != 0, ACC_W'(mHead.data), mHead.cnt, mHead.sat, mCnt != 0, mOvf);
  endtask

  // Drives one cycle of inputs, advances the model, and leaves time 1 ns past the clock edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic last,
                               input logic ready, input logic clr);
    inValid     = v;
    inData      = d;
    inLast      = last;
    outReady    = ready;
    clrOverflow = clr;
    modelStep(v, d, last, ready, clr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              last;
    logic              ready;
    logic              clr;
    logic              expValid;
    logic [ACC_W-1:0]  expData;
    int                expCount;
    logic              expBusy;
    logic              expOvf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 16'hFFFB, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFD, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 24'hFFFFFD, 2, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00000A, 1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0014, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00000A, 1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h001E, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00000A, 1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 24'h00000A, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'h0028, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000014, 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000028, 1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000028, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000001, 1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000001, 1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000001, 1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000002, 1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000002, 1, 1'b0, 1'b0};

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].ready, tbl[i].clr);
      checkOutput($sformatf("vec%0d", i), tbl[i].expValid, tbl[i].expData, tbl[i].expCount,
                  1'b0, tbl[i].expBusy, tbl[i].expOvf);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
      checkModel($sformatf("plus3_%0d", i));
    end
    checkOutput("frame8", 1'b1, 24'd24, 8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkModel("frame8_drain");

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    checkOutput("max8", 1'b1, 24'h03FFF8, 8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    checkOutput("min8", 1'b1, 24'hFC0000, 8, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkModel("pre_reset");
    rst_n = 1'b0;
    #2;
    checkEq("midreset.busy", longint'(busy), 0);
    checkEq("midreset.out_valid", longint'(outValid), 0);
    checkEq("midreset.out_data", longint'(outData), 0);
    modelReset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
      checkModel($sformatf("post_reset_%0d", i));
    end
    checkOutput("post_reset_sum", 1'b1, 24'd8, 8, 1'b0, 1'b0, 1'b0);

    s16Valid = 1'b1;
    s16Data  = 16'h7FFF;
    s16Last  = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    s16Last  = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    s16Valid = 1'b0;
    s16Last  = 1'b0;
    checkEq("acc16.out_valid", longint'(s16OutValid), 1);
    checkEq("acc16.out_count", longint'(s16OutCount), 2);
`ifdef SUB_MUL_ACC_SAT_EN
    checkEq("acc16.out_data", longint'(s16OutData), 64'h7FFF);
    checkEq("acc16.out_sat", longint'(s16OutSat), 1);
`else
    checkEq("acc16.out_data", longint'(s16OutData), 64'hFFFE);
    checkEq("acc16.out_sat", longint'(s16OutSat), 0);
`endif
    checkModel("acc16_idle");

    for (int i = 0; i < 600; i++) begin
      logic [DATA_W-1:0] d;
      case ($urandom_range(0, 5))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = DATA_W'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      checkModel($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
